// File: rtl/ast_pkt_tx_pkg.sv
// Shared types and helpers for the Avalon-ST packet transmitter.
package ast_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bytes carried by one bus word.
  function automatic int unsigned bytes_per_word(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

  // Number of bus words needed to carry len bytes (ceiling division).
  function automatic int unsigned words_for_len(input int unsigned len,
                                                input int unsigned bytes);
    return (len + bytes - 1) / bytes;
  endfunction

endpackage

// File: rtl/ast_pkt_tx_if.sv
// Avalon-ST link: master is the source side, slave is the sink side.
interface avalon_st_if #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = 3
);
  logic [DWIDTH-1:0]        data;
  logic                     valid;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     ready;

  modport master (
    output data, valid, startofpacket, endofpacket, empty, channel,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty, channel,
    output ready
  );
endinterface

// File: rtl/ast_pkt_tx_pattern_gen.sv
// Incrementing-byte pattern word: byte i = seed + offset + i, placed MSB-first;
// bytes at or beyond valid_bytes_i are forced to zero.
module ast_tx_pattern_gen #(
  parameter int DWIDTH = 64
) (
  input  logic [7:0]                  seed_i,
  input  logic [7:0]                  offset_i,
  input  logic [$clog2(DWIDTH/8):0]   valid_bytes_i,
  output logic [DWIDTH-1:0]           data_o
);
  localparam int BYTES = DWIDTH / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;

  logic [7:0] base;
  assign base = seed_i + offset_i;

  // One lane per byte; the mod-256 wrap falls out of the 8-bit add.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign data_o[DWIDTH-1-8*gi -: 8] =
      (CNT_W'(gi) < valid_bytes_i) ? (base + 8'(gi)) : 8'h00;
  end
endmodule

// File: rtl/ast_pkt_tx.sv
// Avalon-ST packet transmitter: turns a (len, chan, seed) command into one
// SOP..EOP packet of incrementing bytes.
// Optional feature macro AST_TX_IDLE_GAP_EN: inserts GAP_CYCLES idle cycles
// after each EOP transfer before the next command can be accepted.
module ast_pkt_tx
  import ast_tx_pkg::*;
#(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int LEN_WIDTH     = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [CHANNEL_WIDTH-1:0] cmd_chan_i,
  input  logic [7:0]               cmd_seed_i,
  output logic                     err_o,
  output logic                     busy_o,
  avalon_st_if.master              src
);
  localparam int BYTES   = int'(bytes_per_word(DWIDTH));
  localparam int CNT_W   = $clog2(BYTES) + 1;
  localparam int EMPTY_W = $clog2(BYTES);

  state_t                   state_q, state_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [LEN_WIDTH-1:0]     words_q, words_d;
  logic [LEN_WIDTH-1:0]     word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]     off_q, off_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic [7:0]               seed_q, seed_d;
  logic                     err_q, err_d;

`ifdef AST_TX_IDLE_GAP_EN
  logic [15:0]              gap_cnt_q, gap_cnt_d;
`else
  logic                     unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_CYCLES;
`endif

  // Bytes still owed for the current word and derived beat attributes.
  logic [LEN_WIDTH-1:0] rem;
  logic [CNT_W-1:0]     valid_cnt;
  logic                 last_word;
  logic [DWIDTH-1:0]    pattern;

  assign rem       = len_q - off_q;
  assign valid_cnt = (rem >= LEN_WIDTH'(BYTES)) ? CNT_W'(BYTES) : rem[CNT_W-1:0];
  assign last_word = (word_cnt_q == words_q - LEN_WIDTH'(1));

  ast_tx_pattern_gen #(.DWIDTH(DWIDTH)) u_pattern (
    .seed_i        (seed_q),
    .offset_i      (off_q[7:0]),
    .valid_bytes_i (valid_cnt),
    .data_o        (pattern)
  );

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      words_q    <= '0;
      word_cnt_q <= '0;
      off_q      <= '0;
      chan_q     <= '0;
      seed_q     <= '0;
      err_q      <= 1'b0;
`ifdef AST_TX_IDLE_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      word_cnt_q <= word_cnt_d;
      off_q      <= off_d;
      chan_q     <= chan_d;
      seed_q     <= seed_d;
      err_q      <= err_d;
`ifdef AST_TX_IDLE_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  // Next-state: accept/reject commands, advance word counters on transfer.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    word_cnt_d = word_cnt_q;
    off_d      = off_q;
    chan_d     = chan_q;
    seed_d     = seed_q;
    err_d      = 1'b0;
`ifdef AST_TX_IDLE_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = SEND;
            len_d      = cmd_len_i;
            chan_d     = cmd_chan_i;
            seed_d     = cmd_seed_i;
            words_d    = LEN_WIDTH'(words_for_len(32'(cmd_len_i), BYTES));
            word_cnt_d = '0;
            off_d      = '0;
          end
        end
      end
      SEND: begin
        if (src.ready) begin
          word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
          off_d      = off_q + LEN_WIDTH'(BYTES);
          if (last_word) begin
`ifdef AST_TX_IDLE_GAP_EN
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_cnt_d = '0;
`else
            state_d   = IDLE;
`endif
          end
        end
      end
      GAP: begin
`ifdef AST_TX_IDLE_GAP_EN
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: purely from registered state, so beats hold stable under stall.
  always_comb begin
    cmd_ready_o       = (state_q == IDLE);
    busy_o            = (state_q != IDLE);
    err_o             = err_q;
    src.valid         = (state_q == SEND);
    src.startofpacket = (state_q == SEND) && (word_cnt_q == '0);
    src.endofpacket   = (state_q == SEND) && last_word;
    src.empty         = '0;
    if ((state_q == SEND) && last_word)
      src.empty = EMPTY_W'(CNT_W'(BYTES) - valid_cnt);
    src.data          = (state_q == SEND) ? pattern : '0;
    src.channel       = chan_q;
  end
endmodule
